acc_tx: RTL and testbench
=========================

// Module: acc_tx
// PURPOSE
//  Frames the 128-bit accumulator result out over the UART transmitter as a byte stream.
//  Sits between the acc block (consumes its big result) and uart (drives transmit/data_tx, obeys busy_tx).
//  On start it snapshots the result, sends a header byte, then BYTES data bytes LSB-first, and pulses done.
// PARAMETERS
//  BYTES   16     data bytes per frame; input width is 8*BYTES
//  HEADER  8'hA5  frame header byte sent before data
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  rst       in   1         reset, asynchronous, active-high
//  start     in   1         request a frame; sampled only in IDLE
//  big       in   8*BYTES   accumulator result, snapshotted on accepted start
//  busy_tx   in   1         uart transmitter busy
//  transmit  out  1         one-cycle strobe to uart, data_tx valid same cycle
//  data_tx   out  8         byte to uart
//  busy      out  1         high from accepted start until done pulse inclusive
//  done      out  1         one-cycle pulse, frame complete
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; transmit=0, data_tx=8'h00, busy=0, done=0, snapshot=0, index=0, csum=0.
//  - Reset mid-frame aborts immediately; no further transmit; a new start is required after rst falls.
//  - States: IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT, DONE.
//  - IDLE: start=1 -> snapshot<=big, index<=0, csum<=0, busy<=1, data_tx<=HEADER, go LOAD.
//    start while busy=1 is ignored (not queued).
//  - LOAD: wait until busy_tx=0, then go STROBE.
//  - STROBE: transmit=1 for exactly this cycle with data_tx stable; go WAIT_HI.
//  - WAIT_HI: wait for busy_tx=1 (uart acceptance); if busy_tx still 0 after 2 cycles, treat byte as sent
//    (go NEXT) to avoid deadlock. busy_tx=1 -> WAIT_LO.
//  - WAIT_LO: wait for busy_tx=0 -> NEXT.
//  - NEXT: if more bytes: data_tx<=snapshot[8*index +: 8], csum<=csum+that byte (mod 256), index++, go LOAD;
//    else go DONE.
//  - DONE: done=1 one cycle, busy<=0, go IDLE. start in DONE cycle is ignored.
//  - Byte order: HEADER, big[7:0], big[15:8], ..., big[8*BYTES-1 -: 8].
//  - data_tx holds last driven byte between strobes and after DONE; changes only in IDLE-accept/NEXT.
//  - index width clog2(BYTES+1); wraps never (terminates at BYTES).
//  - Changes on big after snapshot have no effect on the frame in flight.
//  - Header is not included in checksum.
//  - Minimum frame time with ideal uart: (BYTES+1) strobes; transmit never asserted while busy_tx=1.
// CONFIGURATION
//  ACC_TX_CHECKSUM_EN defined: after the last data byte, one extra byte = 8-bit sum mod 256 of all data
//    bytes is sent with the same LOAD/STROBE/WAIT handshake, then DONE. Frame = BYTES+2 bytes.
//  Not defined: no checksum byte, no csum register; frame = BYTES+1 bytes.
// TESTING
//  1. rst pulse mid-IDLE and mid-frame -> all outputs 0 within same cycle, no transmit after rst falls.
//  2. big=128'h0F0E..0100 (byte k=k), start, uart model busy 10 cycles per byte -> bytes A5,00,01..0F
//     [+78 with ACC_TX_CHECKSUM_EN]; done pulses once; busy high throughout.
//  3. start asserted twice during frame and big changed mid-frame -> single frame, original snapshot bytes only.
//  4. busy_tx held 1 at start for 50 cycles -> no transmit until busy_tx falls, then header strobed.
//  5. uart model never raises busy_tx -> each byte advances after 2-cycle timeout, frame completes, done pulses.
//  6. big=all 8'hFF -> checksum byte 8'hF0 (16*255 mod 256) when ACC_TX_CHECKSUM_EN defined; frame 18 bytes.

Source files
------------

// File: rtl/acc_tx.sv
// acc_tx: frames the 128-bit accumulator result out to the UART as a byte stream.
// Frame: HEADER, then BYTES data bytes LSB-first, then an optional checksum byte.
// Optional feature macro: ACC_TX_CHECKSUM_EN appends an 8-bit modular sum of the data bytes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; snapshots big and loads header on accept
// LOAD     | waiting for the uart to be idle before strobing data_tx
// STROBE   | one-cycle transmit strobe with data_tx stable
// WAIT_HI  | waiting for the uart to accept (busy_tx high), 2-cycle timeout
// WAIT_LO  | waiting for the uart to finish the byte (busy_tx low)
// NEXT     | selects the next data/checksum byte or finishes the frame
// DONE     | one-cycle done pulse, busy drops
module acc_tx #(
  parameter int         BYTES  = 16,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*BYTES-1:0] big,
  input  logic               busy_tx,
  output logic               transmit,
  output logic [7:0]         data_tx,
  output logic               busy,
  output logic               done
);

  localparam int            IW       = $clog2(BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [8*BYTES-1:0] snap_q, snap_d;
  logic [IW-1:0]      index_q, index_d;
  logic               busy_q, busy_d;
  logic [7:0]         data_q, data_d;
  logic               tmo_q, tmo_d;
`ifdef ACC_TX_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
  logic               csum_sent_q, csum_sent_d;
`endif

  // State and datapath registers, cleared asynchronously so a reset aborts a frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      snap_q      <= '0;
      index_q     <= '0;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      tmo_q       <= 1'b0;
`ifdef ACC_TX_CHECKSUM_EN
      csum_q      <= 8'h00;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      index_q     <= index_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
`ifdef ACC_TX_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end

  // Next-state and strobe decode; the snapshot shifts right so its low byte is always the next one.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    index_d     = index_q;
    busy_d      = busy_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
`ifdef ACC_TX_CHECKSUM_EN
    csum_d      = csum_q;
    csum_sent_d = csum_sent_q;
`endif
    transmit    = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d      = big;
          index_d     = '0;
          busy_d      = 1'b1;
          data_d      = HEADER;
`ifdef ACC_TX_CHECKSUM_EN
          csum_d      = 8'h00;
          csum_sent_d = 1'b0;
`endif
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!busy_tx) state_d = S_STROBE;
      end
      S_STROBE: begin
        transmit = 1'b1;
        tmo_d    = 1'b1;
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A uart that never raises busy_tx must not hang the frame.
        if (busy_tx)     state_d = S_WAIT_LO;
        else if (!tmo_q) state_d = S_NEXT;
        else             tmo_d   = 1'b0;
      end
      S_WAIT_LO: begin
        if (!busy_tx) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (index_q != LAST_IDX) begin
          data_d  = snap_q[7:0];
          snap_d  = snap_q >> 8;
          index_d = index_q + IW'(1);
`ifdef ACC_TX_CHECKSUM_EN
          csum_d  = csum_q + snap_q[7:0];
`endif
          state_d = S_LOAD;
        end
`ifdef ACC_TX_CHECKSUM_EN
        else if (!csum_sent_q) begin
          data_d      = csum_q;
          csum_sent_d = 1'b1;
          state_d     = S_LOAD;
        end
`endif
        else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign data_tx = data_q;

endmodule

// File: tb/tb_acc_tx.sv
// Testbench for acc_tx: table-driven frames, randomized frames and hand-written corner sequences.
module tb_acc_tx;

  localparam int BYTES = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [8*BYTES-1:0] big;
  logic               busy_tx = 1'b0;
  logic               transmit;
  logic [7:0]         data_tx;
  logic               busy;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt   = 0;
  int         uart_cnt   = 0;
  int         uart_lat   = 10;
  bit         uart_mute  = 1'b0;
  bit         force_busy = 1'b0;

  typedef struct {
    logic [127:0] big;
    int           lat;
    bit           mute;
    logic [7:0]   csum;
  } vec_t;

  vec_t vecs[5];

  acc_tx #(.BYTES(BYTES), .HEADER(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .big      (big),
    .busy_tx  (busy_tx),
    .transmit (transmit),
    .data_tx  (data_tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART model and monitor: capture strobed bytes, then hold busy_tx for uart_lat cycles.
  always @(negedge clk) begin
    if (!rst && transmit === 1'b1) begin
      rx_q.push_back(data_tx);
      chk("tx_while_busy_tx", int'(busy_tx), 0);
      if (!uart_mute) uart_cnt = uart_lat;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    busy_tx = force_busy || (uart_cnt > 0);
    if (!rst && done === 1'b1) done_cnt++;
  end

  function automatic int model_sum(input logic [127:0] b);
    int s = 0;
    for (int k = 0; k < BYTES; k++) s = s + int'(b[8*k +: 8]);
    return s % 256;
  endfunction

  task automatic build_exp(input logic [127:0] b, input int cs);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < BYTES; k++) exp_q.push_back(b[8*k +: 8]);
`ifdef ACC_TX_CHECKSUM_EN
    exp_q.push_back(cs[7:0]);
`endif
  endtask

  task automatic kick(input logic [127:0] b);
    @(negedge clk);
    rx_q.delete();
    done_cnt = 0;
    big   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit poke_start);
    int cyc     = 0;
    bit busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 5000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, int'(done), 1);
    chk({name, "_busy_through"}, int'(busy_ok), 1);
    chk({name, "_busy_at_done"}, int'(busy), 1);
    if (poke_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_done_width"}, int'(done), 0);
  endtask

  task automatic check_frame(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp_q[i]));
    chk({name, "_done_cnt"}, done_cnt, 1);
  endtask

  logic [127:0] ramp;
  logic [127:0] rb;
  int           n_rx;

  initial begin
    ramp = 128'h0F0E0D0C0B0A09080706050403020100;
    vecs[0] = '{ramp, 10, 1'b0, 8'h78};
    vecs[1] = '{{16{8'hFF}}, 10, 1'b0, 8'hF0};
    vecs[2] = '{128'h0, 3, 1'b0, 8'h00};
    vecs[3] = '{{16{8'h01}}, 5, 1'b1, 8'h10};
    vecs[4] = '{{16{8'h80}}, 1, 1'b0, 8'h00};

    rst = 1'b1; start = 1'b0; big = '0;
    #13;
    chk("rst_transmit", int'(transmit), 0);
    chk("rst_data_tx",  int'(data_tx),  0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_done",     int'(done),     0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      uart_lat  = vecs[v].lat;
      uart_mute = vecs[v].mute;
      build_exp(vecs[v].big, int'(vecs[v].csum));
      kick(vecs[v].big);
      wait_done($sformatf("vec%0d", v), 1'b0);
      check_frame($sformatf("vec%0d", v));
    end
    uart_mute = 1'b0;
    uart_lat  = 10;

    // Reset in IDLE clears the held data_tx immediately.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("idle_rst_data_tx", int'(data_tx), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame aborts; nothing further is transmitted.
    kick(ramp);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_transmit", int'(transmit), 0);
    chk("mid_rst_data_tx",  int'(data_tx),  0);
    chk("mid_rst_busy",     int'(busy),     0);
    chk("mid_rst_done",     int'(done),     0);
    @(negedge clk);
    rst  = 1'b0;
    n_rx = rx_q.size();
    repeat (100) @(negedge clk);
    chk("no_tx_after_rst",  rx_q.size(), n_rx);
    chk("idle_after_rst",   int'(busy), 0);
    chk("no_done_after_rst", done_cnt, 0);

    // Restarts during a frame, big changed mid-frame, start during DONE.
    build_exp(ramp, 8'h78);
    kick(ramp);
    repeat (20) @(negedge clk);
    start = 1'b1; big = ~ramp;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1; big = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    wait_done("restart", 1'b1);
    check_frame("restart");
    repeat (50) @(negedge clk);
    chk("restart_no_second", rx_q.size(), exp_q.size());
    chk("restart_idle", int'(busy), 0);

    // busy_tx held high before the header: no strobe until it falls.
    force_busy = 1'b1;
    rb = {16{8'h3C}};
    build_exp(rb, model_sum(rb));
    kick(rb);
    repeat (50) @(negedge clk);
    chk("held_no_tx", rx_q.size(), 0);
    chk("held_busy",  int'(busy), 1);
    force_busy = 1'b0;
    wait_done("held", 1'b0);
    check_frame("held");

    // Uart that never raises busy_tx: timeout path.
    uart_mute = 1'b1;
    build_exp(ramp, 8'h78);
    kick(ramp);
    wait_done("mute", 1'b0);
    check_frame("mute");
    uart_mute = 1'b0;

    // Randomized frames checked against the model.
    for (int r = 0; r < 8; r++) begin
      rb        = {$urandom, $urandom, $urandom, $urandom};
      uart_lat  = int'($urandom_range(1, 12));
      uart_mute = ($urandom_range(0, 3) == 0);
      build_exp(rb, model_sum(rb));
      kick(rb);
      wait_done($sformatf("rand%0d", r), 1'b0);
      check_frame($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
